pc_fetch: RTL and testbench

Fetch-side companion of the next-PC unit. Holds the architectural word-address PC and fetches the instruction at that PC from instruction memory over a request/grant/response handshake. Presents the PC and instruction word to decode with a valid/ready handshake. On acceptance it loads the next-PC value computed from the presented PC, then fetches again. A watchdog flags memory responses that never arrive, and a counter tracks delivered instructions.

---
 rtl/pc_fetch_if.sv | 24 ++
 rtl/pc_fetch.sv | 78 +++++++
 tb/tb_pc_fetch.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/pc_fetch_if.sv
// Fetch-side bus bundle: instruction memory request/grant/response plus the
// decode valid/ready handshake and the next-PC feedback.
interface pc_fetch_if;
  logic        imem_req;
  logic [29:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [29:0] npc_in;
  logic [29:0] pc_out;
  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_ready;

  modport master (
    output imem_req, imem_addr, pc_out, instr, instr_valid,
    input  imem_gnt, imem_rvalid, imem_rdata, npc_in, instr_ready
  );

  modport slave (
    input  imem_req, imem_addr, pc_out, instr, instr_valid,
    output imem_gnt, imem_rvalid, imem_rdata, npc_in, instr_ready
  );
endinterface

// File: rtl/pc_fetch.sv
// PC register plus single-outstanding instruction fetch FSM with a response
// watchdog and an accepted-instruction counter.
module pc_fetch #(
  parameter logic [29:0] RESET_PC = 30'h0000_0C00,
  parameter int          TIMEOUT  = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  pc_fetch_if.master  bus,
  output logic        fetch_err,
  output logic [31:0] fetch_cnt
);

  localparam logic [7:0] TMAX = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_VALID, S_ERR} state_t;

  state_t      state;
  logic [29:0] pc;
  logic [31:0] instr_q;
  logic [7:0]  tcnt;
  logic        req_q;

  // imem_req is its own register so it can read 0 during reset while the
  // FSM already sits in REQ; it rises on the first edge after release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_REQ;
      pc        <= RESET_PC;
      instr_q   <= '0;
      fetch_cnt <= '0;
      fetch_err <= 1'b0;
      tcnt      <= '0;
      req_q     <= 1'b0;
    end else begin
      case (state)
        S_REQ: begin
          if (!req_q) begin
            req_q <= 1'b1;
          end else if (bus.imem_gnt) begin
            req_q <= 1'b0;
            tcnt  <= '0;
            state <= S_WAIT;
          end
        end
        S_WAIT: begin
          // A response on the final watchdog cycle still wins.
          if (bus.imem_rvalid) begin
            instr_q <= bus.imem_rdata;
            state   <= S_VALID;
          end else if (tcnt == TMAX) begin
            fetch_err <= 1'b1;
            state     <= S_ERR;
          end else begin
            tcnt <= tcnt + 8'd1;
          end
        end
        S_VALID: begin
          if (bus.instr_ready) begin
            pc        <= bus.npc_in;
            fetch_cnt <= fetch_cnt + 32'd1;
            req_q     <= 1'b1;
            state     <= S_REQ;
          end
        end
        S_ERR: ;
        default: state <= S_ERR;
      endcase
    end
  end

  assign bus.imem_req    = req_q;
  assign bus.imem_addr   = pc;
  assign bus.pc_out      = pc;
  assign bus.instr       = instr_q;
  assign bus.instr_valid = (state == S_VALID);

endmodule

// File: tb/tb_pc_fetch.sv
// Directed bench for pc_fetch: startup, streaming, backpressure, slow memory,
// watchdog timeout and asynchronous reset mid-operation.
module tb_pc_fetch;
  logic        clk;
  logic        rst_n;
  logic        fetch_err;
  logic [31:0] fetch_cnt;
  int          checks;
  int          errors;

  pc_fetch_if bus ();

  pc_fetch #(.RESET_PC(30'h0000_0C00), .TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .fetch_err(fetch_err), .fetch_cnt(fetch_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance one cycle; outputs are sampled 1 time unit after the edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.imem_gnt    = 1'b0;
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = 32'h0;
    bus.npc_in      = 30'h0;
    bus.instr_ready = 1'b0;
  endtask

  // Called right after rst_n release: grant on first REQ cycle, zero-wait data.
  task automatic startup(input logic [31:0] rdata);
    cyc();
    checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 30'h0C00) begin errors++;
      $display("FAIL startup_req: req=%b addr=%h want 1/0c00", bus.imem_req, bus.imem_addr); end
    bus.imem_gnt = 1'b1;
    cyc();
    bus.imem_gnt = 1'b0;
    checks++; if (bus.imem_req !== 1'b0 || bus.instr_valid !== 1'b0) begin errors++;
      $display("FAIL startup_wait: req=%b valid=%b want 0/0", bus.imem_req, bus.instr_valid); end
    bus.imem_rvalid = 1'b1; bus.imem_rdata = rdata;
    cyc();
    bus.imem_rvalid = 1'b0;
    checks++; if (bus.instr_valid !== 1'b1 || bus.instr !== rdata || bus.pc_out !== 30'h0C00) begin errors++;
      $display("FAIL startup_valid: valid=%b instr=%h pc=%h want 1/%h/0c00", bus.instr_valid, bus.instr, bus.pc_out, rdata); end
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    repeat (3) cyc();
    checks++; if (bus.imem_req !== 1'b0 || bus.instr_valid !== 1'b0 || bus.pc_out !== 30'h0C00 ||
                  bus.instr !== 32'h0 || fetch_cnt !== 32'h0 || fetch_err !== 1'b0) begin errors++;
      $display("FAIL reset_state: req=%b valid=%b pc=%h instr=%h cnt=%0d err=%b want 0/0/0c00/0/0/0",
               bus.imem_req, bus.instr_valid, bus.pc_out, bus.instr, fetch_cnt, fetch_err); end
    rst_n = 1'b1;
    startup(32'h2401_0005);
    checks++; if (fetch_cnt !== 32'd0) begin errors++;
      $display("FAIL reset_cnt: cnt=%0d want 0", fetch_cnt); end
  endtask

  // From VALID: three accepts with npc=pc+1, zero-wait memory, 3 cycles each.
  task automatic test_stream();
    logic [29:0] pc_exp;
    logic [31:0] d;
    for (int i = 0; i < 3; i++) begin
      pc_exp = 30'h0C00 + 30'(i);
      checks++; if (bus.instr_valid !== 1'b1 || bus.pc_out !== pc_exp) begin errors++;
        $display("FAIL stream_pc%0d: valid=%b pc=%h want 1/%h", i, bus.instr_valid, bus.pc_out, pc_exp); end
      bus.instr_ready = 1'b1; bus.npc_in = pc_exp + 30'd1;
      cyc();
      bus.instr_ready = 1'b0;
      checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== pc_exp + 30'd1 || bus.instr_valid !== 1'b0) begin errors++;
        $display("FAIL stream_req%0d: req=%b addr=%h valid=%b want 1/%h/0", i, bus.imem_req, bus.imem_addr, bus.instr_valid, pc_exp + 30'd1); end
      bus.imem_gnt = 1'b1;
      cyc();
      bus.imem_gnt = 1'b0;
      d = 32'hA000_0000 + 32'(i);
      bus.imem_rvalid = 1'b1; bus.imem_rdata = d;
      cyc();
      bus.imem_rvalid = 1'b0;
      checks++; if (bus.instr_valid !== 1'b1 || bus.instr !== d) begin errors++;
        $display("FAIL stream_instr%0d: valid=%b instr=%h want 1/%h", i, bus.instr_valid, bus.instr, d); end
    end
    checks++; if (fetch_cnt !== 32'd3 || bus.pc_out !== 30'h0C03) begin errors++;
      $display("FAIL stream_cnt: cnt=%0d pc=%h want 3/0c03", fetch_cnt, bus.pc_out); end
  endtask

  // VALID at pc 0C03 holding instr A0000002; stall 5 cycles then redirect.
  task automatic test_backpressure();
    for (int i = 0; i < 5; i++) begin
      bus.instr_ready = 1'b0; bus.npc_in = 30'h1000 + 30'(i * 7);
      cyc();
      checks++; if (bus.instr_valid !== 1'b1 || bus.pc_out !== 30'h0C03 ||
                    bus.instr !== 32'hA000_0002 || bus.imem_req !== 1'b0) begin errors++;
        $display("FAIL bp_stall%0d: valid=%b pc=%h instr=%h req=%b want 1/0c03/a0000002/0",
                 i, bus.instr_valid, bus.pc_out, bus.instr, bus.imem_req); end
    end
    bus.instr_ready = 1'b1; bus.npc_in = 30'h0D10;
    cyc();
    bus.instr_ready = 1'b0;
    checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 30'h0D10 || bus.pc_out !== 30'h0D10 ||
                  fetch_cnt !== 32'd4) begin errors++;
      $display("FAIL bp_redirect: req=%b addr=%h pc=%h cnt=%0d want 1/0d10/0d10/4",
               bus.imem_req, bus.imem_addr, bus.pc_out, fetch_cnt); end
  endtask

  // REQ at 0D10: grant after 4 cycles (spurious rvalid meanwhile), data after 10 WAIT cycles.
  task automatic test_slow_mem();
    for (int i = 0; i < 4; i++) begin
      bus.imem_rvalid = i[0]; bus.imem_rdata = 32'hDEAD_0000 + 32'(i);
      cyc();
      checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 30'h0D10 ||
                    bus.instr_valid !== 1'b0 || bus.instr !== 32'hA000_0002) begin errors++;
        $display("FAIL slow_req%0d: req=%b addr=%h valid=%b instr=%h want 1/0d10/0/a0000002",
                 i, bus.imem_req, bus.imem_addr, bus.instr_valid, bus.instr); end
    end
    bus.imem_rvalid = 1'b0;
    bus.imem_gnt = 1'b1;
    cyc();
    bus.imem_gnt = 1'b0;
    repeat (10) cyc();
    checks++; if (bus.imem_req !== 1'b0 || bus.instr_valid !== 1'b0 || fetch_err !== 1'b0) begin errors++;
      $display("FAIL slow_wait: req=%b valid=%b err=%b want 0/0/0", bus.imem_req, bus.instr_valid, fetch_err); end
    bus.imem_rvalid = 1'b1; bus.imem_rdata = 32'h1234_5678;
    cyc();
    bus.imem_rvalid = 1'b0;
    checks++; if (bus.instr_valid !== 1'b1 || bus.instr !== 32'h1234_5678 || fetch_err !== 1'b0) begin errors++;
      $display("FAIL slow_capture: valid=%b instr=%h err=%b want 1/12345678/0", bus.instr_valid, bus.instr, fetch_err); end
    bus.instr_ready = 1'b1; bus.npc_in = 30'h0D11;
    cyc();
    bus.instr_ready = 1'b0;
  endtask

  // REQ at 0D11, fetch_cnt=5: grant then 16 silent WAIT cycles.
  task automatic test_timeout();
    bus.imem_gnt = 1'b1;
    cyc();
    bus.imem_gnt = 1'b0;
    repeat (15) cyc();
    checks++; if (fetch_err !== 1'b0) begin errors++;
      $display("FAIL to_early: err=%b want 0 after 15 wait cycles", fetch_err); end
    cyc();
    checks++; if (fetch_err !== 1'b1 || bus.imem_req !== 1'b0 || bus.instr_valid !== 1'b0) begin errors++;
      $display("FAIL to_err: err=%b req=%b valid=%b want 1/0/0", fetch_err, bus.imem_req, bus.instr_valid); end
    bus.imem_rvalid = 1'b1; bus.imem_rdata = 32'hBAD0_BAD0;
    bus.imem_gnt = 1'b1; bus.instr_ready = 1'b1; bus.npc_in = 30'h0333;
    repeat (4) cyc();
    idle_inputs();
    checks++; if (fetch_err !== 1'b1 || bus.imem_req !== 1'b0 || bus.instr_valid !== 1'b0 ||
                  bus.pc_out !== 30'h0D11 || fetch_cnt !== 32'd5 || bus.instr !== 32'h1234_5678) begin errors++;
      $display("FAIL to_frozen: err=%b req=%b valid=%b pc=%h cnt=%0d instr=%h want 1/0/0/0d11/5/12345678",
               fetch_err, bus.imem_req, bus.instr_valid, bus.pc_out, fetch_cnt, bus.instr); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (fetch_err !== 1'b0 || bus.pc_out !== 30'h0C00 || fetch_cnt !== 32'd0) begin errors++;
      $display("FAIL to_reset: err=%b pc=%h cnt=%0d want 0/0c00/0", fetch_err, bus.pc_out, fetch_cnt); end
    rst_n = 1'b1;
    // Boundary: response on the 16th WAIT cycle must win over the watchdog.
    cyc();
    bus.imem_gnt = 1'b1;
    cyc();
    bus.imem_gnt = 1'b0;
    repeat (15) cyc();
    bus.imem_rvalid = 1'b1; bus.imem_rdata = 32'h0F0F_0016;
    cyc();
    bus.imem_rvalid = 1'b0;
    checks++; if (fetch_err !== 1'b0 || bus.instr_valid !== 1'b1 || bus.instr !== 32'h0F0F_0016) begin errors++;
      $display("FAIL to_boundary: err=%b valid=%b instr=%h want 0/1/0f0f0016", fetch_err, bus.instr_valid, bus.instr); end
  endtask

  // VALID at 0C00: accept, reach WAIT, reset asynchronously; then again in VALID.
  task automatic test_reset_mid();
    bus.instr_ready = 1'b1; bus.npc_in = 30'h0E00;
    cyc();
    bus.instr_ready = 1'b0;
    bus.imem_gnt = 1'b1;
    cyc();
    bus.imem_gnt = 1'b0;
    checks++; if (fetch_cnt !== 32'd1 || bus.pc_out !== 30'h0E00) begin errors++;
      $display("FAIL mid_pre: cnt=%0d pc=%h want 1/0e00", fetch_cnt, bus.pc_out); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (bus.imem_req !== 1'b0 || bus.instr_valid !== 1'b0 || bus.pc_out !== 30'h0C00 ||
                  fetch_cnt !== 32'd0 || bus.instr !== 32'h0) begin errors++;
      $display("FAIL mid_wait_rst: req=%b valid=%b pc=%h cnt=%0d instr=%h want 0/0/0c00/0/0",
               bus.imem_req, bus.instr_valid, bus.pc_out, fetch_cnt, bus.instr); end
    rst_n = 1'b1;
    startup(32'h5555_AAAA);
    #2 rst_n = 1'b0;
    #1;
    checks++; if (bus.instr_valid !== 1'b0 || bus.imem_req !== 1'b0 || bus.pc_out !== 30'h0C00 ||
                  bus.instr !== 32'h0 || fetch_cnt !== 32'd0) begin errors++;
      $display("FAIL mid_valid_rst: valid=%b req=%b pc=%h instr=%h cnt=%0d want 0/0/0c00/0/0",
               bus.instr_valid, bus.imem_req, bus.pc_out, bus.instr, fetch_cnt); end
    rst_n = 1'b1;
    startup(32'h0000_0013);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    idle_inputs();
    test_reset();
    test_stream();
    test_backpressure();
    test_slow_mem();
    test_timeout();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, time=%0t", $time);
    $fatal(1);
  end
endmodule
